// File: rtl/apb_slave_mem.sv
// APB completer holding a DEPTH x DATA_WIDTH register memory, with a fixed number
// of inserted wait states and PSLVERR on out-of-range addresses.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Full-width compare: addresses at or above DEPTH never alias into the array.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= DEPTH_LIM);
  endfunction

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    setup, mem_we, ready_nxt;
  logic [ADDR_WIDTH-1:0]   addr_p0, addr_sel;
  logic [DATA_WIDTH-1:0]   wdata_p0, rdata_nxt;
  logic                    write_p0, write_sel, err_sel;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    setup     = 1'b0;
    mem_we    = 1'b0;
    ready_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          cnt_nxt = WS_INIT;
          if (WS_INIT == 4'd0) begin
            state_nxt = ST_READY;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt = ST_READY;
            ready_nxt = 1'b1;
          end
        end
      end
      ST_READY: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
        mem_we    = PSEL && write_p0 && !addr_err(addr_p0);
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // With zero wait states the response is built in the setup cycle itself,
  // so the live bus values are used instead of the not-yet-latched copies.
  always_comb begin
    addr_sel  = setup ? PADDR  : addr_p0;
    write_sel = setup ? PWRITE : write_p0;
    err_sel   = addr_err(addr_sel);
    rdata_nxt = '0;
    if (ready_nxt && !write_sel && !err_sel)
      rdata_nxt = mem[addr_sel[IDX_W-1:0]];
  end

  // Stage p0: transfer attributes captured at the setup phase.
  always_ff @(posedge PCLK) begin
    if (setup) begin
      addr_p0  <= PADDR;
      wdata_p0 <= PWDATA;
      write_p0 <= PWRITE;
    end
  end

  // Stage p1: registered response, valid only in the READY cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= ready_nxt;
      PSLVERR <= ready_nxt && err_sel;
      PRDATA  <= rdata_nxt;
    end
  end

  // Memory is deliberately outside reset so contents survive PRESET.
  always_ff @(posedge PCLK) begin
    if (mem_we && !PRESET)
      mem[addr_p0[IDX_W-1:0]] <= wdata_p0;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1, 0 and 3 wait states) driven with
// directed and random APB transfers, checked against an array memory model.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       preset;
  logic       psel [3];
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready [3];
  logic       pslverr [3];
  logic [7:0] prdata [3];

  int tests  = 0;
  int failed = 0;
  int ws_tab [3] = '{1, 0, 3};

  logic [7:0] model [3][64];
  bit         valid [3][64];

  always #5 clk = ~clk;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(1)) u_dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) u_dut1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_dut2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // mode 0: complete, 1: drop PSEL in first access cycle, 2: PRESET in first access cycle
  task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input int mode);
    int         lows;
    bit         err;
    logic [7:0] exp_rd;
    err    = (addr >= 8'd64);
    exp_rd = err ? 8'h00 : model[inst][addr[5:0]];
    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    check("setup_pready", 32'(pready[inst]), 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    if (mode != 0) begin
      if (mode == 1) begin psel[inst] = 1'b0; penable = 1'b0; end
      else preset = 1'b1;
      @(negedge clk);
      check("access1_pready", 32'(pready[inst]), 32'd0);
      @(posedge clk); #1;
      preset = 1'b0;
      @(negedge clk);
      check("after_abort_pready", 32'(pready[inst]), 32'd0);
      @(posedge clk); #1;
      psel[inst] = 1'b0; penable = 1'b0;
      repeat (4) begin
        @(negedge clk);
        check("quiet_pready", 32'(pready[inst]), 32'd0);
        @(posedge clk); #1;
      end
      return;
    end
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pready[inst]) break;
      lows++;
      check("wait_outputs", {23'd0, pslverr[inst], prdata[inst]}, 32'd0);
      @(posedge clk); #1;
    end
    check("latency", 32'(lows), 32'(ws_tab[inst]));
    if (lows < 20) begin
      check("pslverr", 32'(pslverr[inst]), 32'(err));
      if (!wr) check("prdata", 32'(prdata[inst]), 32'(exp_rd));
      @(posedge clk); #1;
    end
    psel[inst] = 1'b0; penable = 1'b0;
    if (wr && !err) begin
      model[inst][addr[5:0]] = data;
      valid[inst][addr[5:0]] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         inst;
    bit         wr;
    logic [7:0] addr, data;
    preset = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_pready", 32'(pready[i]), 32'd0);
      check("reset_outs", {23'd0, pslverr[i], prdata[i]}, 32'd0);
    end
    @(posedge clk); #1;
    preset = 1'b0;
    idle(1);

    xfer(0, 1'b1, 8'd60, 8'hD9, 0);
    xfer(0, 1'b0, 8'd60, 8'h00, 0);
    idle(1);

    xfer(0, 1'b1, 8'd54, 8'h9D, 0);
    xfer(0, 1'b1, 8'd43, 8'h59, 0);
    xfer(0, 1'b1, 8'd32, 8'h91, 0);
    xfer(0, 1'b0, 8'd54, 8'h00, 0);
    xfer(0, 1'b0, 8'd43, 8'h00, 0);
    xfer(0, 1'b0, 8'd32, 8'h00, 0);
    idle(2);

    xfer(0, 1'b1, 8'hDE, 8'h09, 0);
    xfer(0, 1'b0, 8'hDE, 8'h00, 0);
    xfer(0, 1'b0, 8'd60, 8'h00, 0);
    xfer(0, 1'b0, 8'h40, 8'h00, 0);
    idle(1);

    xfer(1, 1'b1, 8'd5, 8'hA5, 0);
    xfer(1, 1'b0, 8'd5, 8'h00, 0);
    xfer(1, 1'b1, 8'hFF, 8'h33, 0);
    xfer(2, 1'b1, 8'd63, 8'h3C, 0);
    xfer(2, 1'b0, 8'd63, 8'h00, 0);
    idle(1);

    xfer(0, 1'b1, 8'd12, 8'hF9, 0);
    xfer(0, 1'b1, 8'd12, 8'hBB, 2);
    xfer(0, 1'b0, 8'd12, 8'h00, 0);
    xfer(0, 1'b0, 8'd60, 8'h00, 0);
    xfer(1, 1'b0, 8'd5, 8'h00, 0);

    xfer(0, 1'b1, 8'd23, 8'h11, 0);
    xfer(0, 1'b1, 8'd23, 8'hB3, 1);
    xfer(0, 1'b0, 8'd23, 8'h00, 0);
    xfer(2, 1'b1, 8'd7, 8'h77, 0);
    xfer(2, 1'b1, 8'd7, 8'hEE, 1);
    xfer(2, 1'b0, 8'd7, 8'h00, 0);

    for (int n = 0; n < 80; n++) begin
      inst = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                          : 8'($urandom_range(0, 63));
      data = 8'($urandom);
      if (!wr && addr < 8'd64 && !valid[inst][addr[5:0]]) wr = 1'b1;
      xfer(inst, wr, addr, data, 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
